// File: rtl/axi_slave_pkg.sv
// Shared types and helpers for the parametrised AXI4 memory slave.
package axi_slave_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef logic [1:0] wstate_t;
  localparam wstate_t W_IDLE = 2'd0;
  localparam wstate_t W_DATA = 2'd1;
  localparam wstate_t W_RESP = 2'd2;

  typedef logic rstate_t;
  localparam rstate_t R_IDLE = 1'b0;
  localparam rstate_t R_DATA = 1'b1;

  // Wrapping bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address sequencer: tracks the beat address/count and flags illegal beats.
// Also exposes the values the registers will hold after this edge, for registered memory reads.
module axi_burst_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [7:0]        start_len,
  input  logic [2:0]        start_size,
  input  logic [1:0]        start_burst,
  output logic              last,
  output logic              err,
  output logic [IDX_W-1:0]  idx,
  output logic              nxt_last,
  output logic              nxt_err,
  output logic [IDX_W-1:0]  nxt_idx
);

  localparam int                LB      = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        len_reg, len_next;
  logic [2:0]        size_reg, size_next;
  logic [1:0]        burst_reg, burst_next;
  logic [7:0]        beat_reg, beat_next;

  function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] b, c, incr, res;
    b    = ONE << size;
    c    = (ADDR_W'(len) + ONE) << size;
    incr = (a & ~(b - ONE)) + b;
    case (burst)
      FIXED:   res = a;
      WRAP:    res = (a & ~(c - ONE)) | (incr & (c - ONE));
      default: res = incr;
    endcase
    return res;
  endfunction

  function automatic logic bad_beat(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (size > 3'(LB)) || (burst == WRAP && !wrap_len_ok(len)) || (burst == 2'b11) ||
           (a < BASE_ADDR) || ((off >> LB) >= DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> LB;
    return off[IDX_W-1:0];
  endfunction

  always_comb begin
    addr_next  = addr_reg;
    len_next   = len_reg;
    size_next  = size_reg;
    burst_next = burst_reg;
    beat_next  = beat_reg;
    if (start) begin
      addr_next  = start_addr;
      len_next   = start_len;
      size_next  = start_size;
      burst_next = start_burst;
      beat_next  = '0;
    end else if (step) begin
      addr_next = advance(addr_reg, len_reg, size_reg, burst_reg);
      beat_next = beat_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      burst_reg <= '0;
      beat_reg  <= '0;
    end else begin
      addr_reg  <= addr_next;
      len_reg   <= len_next;
      size_reg  <= size_next;
      burst_reg <= burst_next;
      beat_reg  <= beat_next;
    end
  end

  assign last     = (beat_reg == len_reg);
  assign err      = bad_beat(addr_reg, len_reg, size_reg, burst_reg);
  assign idx      = word_of(addr_reg);
  assign nxt_last = (beat_next == len_next);
  assign nxt_err  = bad_beat(addr_next, len_next, size_next, burst_next);
  assign nxt_idx  = word_of(addr_next);

endmodule

// File: rtl/axi_slave_mem_p.sv
// AXI4 slave backed by a byte-enabled word memory; one write and one read burst in flight at a time,
// with the two channels running independently.
module axi_slave_mem_p
  import axi_slave_pkg::*;
#(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic              up_reg;
  wstate_t           wstate_reg;
  rstate_t           rstate_reg;
  logic [ID_W-1:0]   bid_reg, rid_reg;
  logic              berr_reg, rerr_reg, rok_reg, rlast_reg, rvalid_reg;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] mem_q;

  logic              aw_hs, w_hs, ar_hs, r_hs, r_load;
  logic              w_last, w_err;
  logic [IDX_W-1:0]  w_idx;
  logic              r_nxt_last, r_nxt_err;
  logic [IDX_W-1:0]  r_nxt_idx;
  logic              w_unused_nxt_last, w_unused_nxt_err, r_unused_last, r_unused_err;
  logic [IDX_W-1:0]  w_unused_nxt_idx, r_unused_idx;

  // Ready outputs stay low until the first edge after reset release.
  assign awready = up_reg && (wstate_reg == W_IDLE);
  assign wready  = (wstate_reg == W_DATA);
  assign bvalid  = (wstate_reg == W_RESP);
  assign arready = up_reg && (rstate_reg == R_IDLE);
  assign bid     = bid_reg;
  assign bresp   = berr_reg ? SLVERR : OKAY;
  assign rid     = rid_reg;
  assign rvalid  = rvalid_reg;
  assign rlast   = rlast_reg;
  assign rresp   = rerr_reg ? SLVERR : OKAY;
  assign rdata   = rok_reg ? mem_q : '0;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid_reg && rready;
  assign r_load = ar_hs || (r_hs && !rlast_reg);

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_wr_gen (
    .clk(aclk), .rst(arst), .start(aw_hs), .step(w_hs),
    .start_addr(awaddr), .start_len(awlen), .start_size(awsize), .start_burst(awburst),
    .last(w_last), .err(w_err), .idx(w_idx),
    .nxt_last(w_unused_nxt_last), .nxt_err(w_unused_nxt_err), .nxt_idx(w_unused_nxt_idx)
  );

  axi_burst_addr_gen #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
  ) u_rd_gen (
    .clk(aclk), .rst(arst), .start(ar_hs), .step(r_hs),
    .start_addr(araddr), .start_len(arlen), .start_size(arsize), .start_burst(arburst),
    .last(r_unused_last), .err(r_unused_err), .idx(r_unused_idx),
    .nxt_last(r_nxt_last), .nxt_err(r_nxt_err), .nxt_idx(r_nxt_idx)
  );

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) up_reg <= 1'b0;
    else      up_reg <= 1'b1;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wstate_reg <= W_IDLE;
      bid_reg    <= '0;
      berr_reg   <= 1'b0;
    end else begin
      case (wstate_reg)
        W_IDLE: if (aw_hs) begin
          wstate_reg <= W_DATA;
          bid_reg    <= awid;
          berr_reg   <= 1'b0;
        end
        W_DATA: if (w_hs) begin
          // Error status accumulates over the whole burst, including wlast misplacement.
          berr_reg <= berr_reg || w_err || (wlast != w_last);
          if (w_last) wstate_reg <= W_RESP;
        end
        W_RESP: if (bready) wstate_reg <= W_IDLE;
        default: wstate_reg <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      rstate_reg <= R_IDLE;
      rvalid_reg <= 1'b0;
      rid_reg    <= '0;
      rlast_reg  <= 1'b0;
      rerr_reg   <= 1'b0;
      rok_reg    <= 1'b0;
    end else begin
      case (rstate_reg)
        R_IDLE: if (ar_hs) begin
          rstate_reg <= R_DATA;
          rvalid_reg <= 1'b1;
          rid_reg    <= arid;
        end
        R_DATA: if (r_hs && rlast_reg) begin
          rstate_reg <= R_IDLE;
          rvalid_reg <= 1'b0;
        end
        default: rstate_reg <= R_IDLE;
      endcase
      // Beat attributes are captured alongside the memory read so they hold during stalls.
      if (r_load) begin
        rlast_reg <= r_nxt_last;
        rerr_reg  <= r_nxt_err;
        rok_reg   <= !r_nxt_err;
      end
    end
  end

  // Registered read of the pre-write contents gives read-before-write on a same-word collision.
  always_ff @(posedge aclk) begin
    if (w_hs && !w_err) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (r_load) mem_q <= mem[r_nxt_idx];
  end

endmodule

// File: tb/tb_axi_slave_mem_p.sv
// Scoreboard bench for axi_slave_mem_p: expected responses are queued when a burst is issued.
module tb_axi_slave_mem_p;
  import axi_slave_pkg::*;

  logic        aclk = 1'b0;
  logic        arst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  always #5 aclk = ~aclk;

  axi_slave_mem_p #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h0)
  ) dut (
    .aclk(aclk), .arst(arst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [31:0] wdq[$];
  logic [3:0]  next_id = 4'd1;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
    rexp_t e;
    e.data = data;
    e.resp = resp;
    e.last = last;
    rq.push_back(e);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [3:0] strb, input logic bad_last,
                    input logic [1:0] exp_resp);
    logic [3:0] id;
    logic [1:0] e;
    int t;
    id = next_id;
    next_id++;
    bq.push_back(exp_resp);
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge aclk); t++; end
    check("awready", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata  = (wdq.size() > 0) ? wdq.pop_front() : 32'h0;
      wstrb  = strb;
      wlast  = (i == int'(len)) && !bad_last;
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge aclk); t++; end
      check("wready", wready, 1);
      @(negedge aclk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    check("bvalid_lat", bvalid, 1);
    t = 0;
    while (!bvalid && t < 50) begin @(negedge aclk); t++; end
    e = bq.pop_front();
    check("bresp", bresp, e);
    check("bid", bid, id);
    $display("WR addr=0x%08h len=%0d size=%0d burst=%0d bresp=%02b", addr, len, size, burst, bresp);
    @(negedge aclk);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                    input logic [1:0] burst, input logic toggle);
    logic [3:0]  id;
    logic [31:0] snap;
    logic        stalled;
    rexp_t       e;
    int          t, beats, cyc;
    id = next_id;
    next_id++;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge aclk); t++; end
    check("arready", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_lat", rvalid, 1);
    beats = 0;
    cyc = 0;
    stalled = 1'b0;
    snap = '0;
    while (beats <= int'(len) && cyc < 200) begin
      if (stalled) begin
        check("r_stable", rdata, snap);
        stalled = 1'b0;
      end
      rready = toggle ? cyc[0] : 1'b1;
      if (rvalid && rready) begin
        if (rq.size() == 0) begin
          check("rq_nonempty", 0, 1);
        end else begin
          e = rq.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", rresp, e.resp);
          check("rlast", rlast, e.last);
          check("rid", rid, id);
        end
        beats++;
      end else if (rvalid) begin
        snap = rdata;
        stalled = 1'b1;
      end
      @(negedge aclk);
      cyc++;
    end
    rready = 1'b1;
    check("r_beats", beats, int'(len) + 1);
    $display("RD addr=0x%08h len=%0d size=%0d burst=%0d beats=%0d", addr, len, size, burst, beats);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;
    repeat (2) @(negedge aclk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    arst = 1'b0;
    #1 check("rel_awready", awready, 0);
    @(negedge aclk);
    check("up_awready", awready, 1);
    check("up_arready", arready, 1);

    // single beat
    wdq.push_back(32'hDEADBEEF);
    wr(32'h10, 8'd0, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    push_beat(32'hDEADBEEF, OKAY, 1'b1);
    rd(32'h10, 8'd0, 3'd2, INCR, 1'b0);

    // INCR burst, read back under rready back-pressure
    for (int i = 1; i <= 4; i++) wdq.push_back(32'(i));
    wr(32'h100, 8'd3, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    for (int i = 1; i <= 4; i++) push_beat(32'(i), OKAY, i == 4);
    rd(32'h100, 8'd3, 3'd2, INCR, 1'b1);

    // WRAP: beats land at 0x38,0x3C,0x30,0x34
    for (int i = 0; i < 4; i++) wdq.push_back(32'hA000_0000 + 32'(i));
    wr(32'h38, 8'd3, 3'd2, WRAP, 4'hF, 1'b0, OKAY);
    push_beat(32'hA000_0002, OKAY, 1'b0);
    push_beat(32'hA000_0003, OKAY, 1'b0);
    push_beat(32'hA000_0000, OKAY, 1'b0);
    push_beat(32'hA000_0001, OKAY, 1'b1);
    rd(32'h30, 8'd3, 3'd2, INCR, 1'b0);
    for (int i = 0; i < 4; i++) push_beat(32'hA000_0000 + 32'(i), OKAY, i == 3);
    rd(32'h38, 8'd3, 3'd2, WRAP, 1'b1);

    // byte strobes and FIXED bursts
    wdq.push_back(32'h11223344);
    wr(32'h20, 8'd0, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    wdq.push_back(32'hAABBCCDD);
    wr(32'h20, 8'd0, 3'd2, INCR, 4'b0101, 1'b0, OKAY);
    push_beat(32'h11BB33DD, OKAY, 1'b1);
    rd(32'h20, 8'd0, 3'd2, INCR, 1'b0);
    wdq.push_back(32'h5); wdq.push_back(32'h6); wdq.push_back(32'h7);
    wr(32'h24, 8'd2, 3'd2, FIXED, 4'hF, 1'b0, OKAY);
    push_beat(32'h7, OKAY, 1'b0);
    push_beat(32'h7, OKAY, 1'b1);
    rd(32'h24, 8'd1, 3'd2, FIXED, 1'b0);

    // error responses
    wdq.push_back(32'h55AA55AA);
    wr(32'h0, 8'd0, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    wdq.push_back(32'h12345678);
    wr(32'h1000, 8'd0, 3'd2, INCR, 4'hF, 1'b0, SLVERR);
    push_beat(32'h0, SLVERR, 1'b1);
    rd(32'h1000, 8'd0, 3'd2, INCR, 1'b0);
    push_beat(32'h55AA55AA, OKAY, 1'b1);
    rd(32'h0, 8'd0, 3'd2, INCR, 1'b0);
    wdq.push_back(32'hCAFEF00D);
    wr(32'h40, 8'd0, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    wdq.push_back(32'h99999999);
    wr(32'h40, 8'd0, 3'd3, INCR, 4'hF, 1'b0, SLVERR);
    push_beat(32'hCAFEF00D, OKAY, 1'b1);
    rd(32'h40, 8'd0, 3'd2, INCR, 1'b0);
    push_beat(32'h0, SLVERR, 1'b1);
    rd(32'h40, 8'd0, 3'd3, INCR, 1'b0);
    wdq.push_back(32'h1); wdq.push_back(32'h2);
    wr(32'h60, 8'd1, 3'd2, INCR, 4'hF, 1'b1, SLVERR);
    for (int i = 0; i < 3; i++) wdq.push_back(32'hBAD0_0000 + 32'(i));
    wr(32'h80, 8'd2, 3'd2, WRAP, 4'hF, 1'b0, SLVERR);

    // reset during read beat 2
    @(negedge aclk);
    arid = 4'h9; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = INCR; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    rready = 1'b1;
    check("t6_rvalid", rvalid, 1);
    check("t6_beat1", rdata, 32'h1);
    @(negedge aclk);
    check("t6_beat2", rdata, 32'h2);
    rready = 1'b0;
    #2 arst = 1'b1;
    #1;
    check("t6_rvalid_rst", rvalid, 0);
    check("t6_arready_rst", arready, 0);
    check("t6_awready_rst", awready, 0);
    check("t6_rdata_rst", rdata, 0);
    @(negedge aclk);
    arst = 1'b0;
    #1 check("t6_arready_rel", arready, 0);
    @(negedge aclk);
    check("t6_arready_up", arready, 1);
    check("t6_awready_up", awready, 1);
    rready = 1'b1;
    for (int i = 1; i <= 4; i++) push_beat(32'(i), OKAY, i == 4);
    rd(32'h100, 8'd3, 3'd2, INCR, 1'b0);
    wdq.push_back(32'h0BADF00D);
    wr(32'h200, 8'd0, 3'd2, INCR, 4'hF, 1'b0, OKAY);
    push_beat(32'h0BADF00D, OKAY, 1'b1);
    rd(32'h200, 8'd0, 3'd2, INCR, 1'b0);

    check("rq_drained", rq.size(), 0);
    check("bq_drained", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
